hawk_att_lkup: RTL and testbench
================================

HAWK_ATT_LKUP -- requirements
Module: hawk_att_lkup

Interface
REQ-001 SHALL have parameter ATT_BASE, default HAWK_ATT_START: byte address of ATT entry 0.
REQ-002 SHALL have parameter HPPA_BASE, default HPPA_BASE_ADDR: byte address mapped to ATT index 0.
REQ-003 SHALL have parameter ENTRY_CNT, default ATT_ENTRY_CNT: number of valid ATT indices.
REQ-004 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port lkup_req_i, input, att_lkup_reqpkt_t: lookup request; `lookup` acts as valid.
REQ-007 SHALL have port lkup_ready_o, output, 1: request accepted when lookup && lkup_ready_o.
REQ-008 SHALL have port rd_req_o, output, axi_rd_reqpkt_t: AXI read address and rready.
REQ-009 SHALL have port rd_rdy_i, input, axi_rd_rdypkt_t: arready.
REQ-010 SHALL have port rd_resp_i, input, axi_rd_resppkt_t: AXI read data beat.
REQ-011 SHALL have port trnsl_o, output, trnsl_reqpkt_t: translation result.
REQ-012 SHALL have port trnsl_valid_o, output, 1: trnsl_o valid.
REQ-013 SHALL have port trnsl_ready_i, input, 1: consumer accepts trnsl_o.
REQ-014 SHALL have port lkup_err_o, output, 1: out-of-range index or non-OKAY rresp; qualified by trnsl_valid_o.

Function
REQ-015 SHALL implement the FSM IDLE -> ADDR -> DATA -> RESP -> IDLE; lkup_ready_o=1 only in IDLE.
REQ-016 SHALL, on acceptance, register hppa and zeroBlkWr and compute idx = hppa - HPPA_BASE[ADDR_W-1:12], with ADDR_W = HACD_AXI4_ADDR_WIDTH.
REQ-017 SHALL, if idx >= ENTRY_CNT, go IDLE -> RESP without any AXI read, with lkup_err_o=1, allow_access=0, zpd_update=0 and ppa=0.
REQ-018 SHALL otherwise drive, in ADDR: arvalid=1, addr = ATT_BASE + (idx>>3)*64, arlen=0; addr and arlen held stable until arvalid && arready.
REQ-019 SHALL, in DATA: drive rready=1; ignore beats with rlast=0; on rvalid && rlast, capture rdata and rresp and move to RESP on the next cycle.
REQ-020 SHALL byte-swap the captured line per 8-byte word (package helper get_8byte_byteswap) and select AttEntry = swapped[64*idx[2:0] +: 64].
REQ-021 SHALL drive trnsl_o.sts = entry.sts.
REQ-022 SHALL drive trnsl_o.ppa[ADDR_W-1:12] = entry bits [ADDR_W-1:12] and trnsl_o.ppa[11:0] = 0.
REQ-023 SHALL drive allow_access=1 iff sts is STS_UNCOMP or STS_INCOMP and rresp==0; otherwise 0.
REQ-024 SHALL, when zeroBlkWr was set, drive zpd_update=1 and zpd_cnt = entry.zpd_cnt+1, saturating at 8'hFF; otherwise zpd_update=0 and zpd_cnt = entry.zpd_cnt.
REQ-025 SHALL, if rresp != 0, drive lkup_err_o=1 and allow_access=0.
REQ-026 SHALL, in RESP: hold trnsl_valid_o=1 with stable trnsl_o and lkup_err_o until trnsl_ready_i; return to IDLE on the cycle after the handshake.
REQ-027 SHALL have latency from acceptance to trnsl_valid_o of 3 cycles, given arready and rvalid/rlast returned at the earliest opportunity.
REQ-028 SHALL accept no new request until the RESP handshake completes (single outstanding lookup).

Reset
REQ-029 SHALL, while rst_ni=0, force state=IDLE and all outputs to 0 except lkup_ready_o, which SHALL be 1 after reset.
REQ-030 SHALL, on reset mid-operation, abandon any in-flight AXI read with no response generated; the interconnect is reset jointly.

Structure
REQ-031 SHALL take AttEntry, att_lkup_reqpkt_t, trnsl_reqpkt_t, the axi_rd_* packets, the STS_* constants and the swap helper from hacd_pkg; new shared types SHALL be added to hacd_pkg.
REQ-032 SHALL be a single module with no sub-module; the entry-select and byte-swap logic stays combinational in the same file.

Verification (ATT_BASE=0xC0000000, HPPA_BASE=0xC0400000, ENTRY_CNT=8)
REQ-033 SHALL cover: hppa=0xC0403, slot 3 entry sts=01 and way giving ppa 0x12345000 -> araddr=0xC0000000, arlen=0, trnsl ppa=0x12345000, allow_access=1, latency 3.
REQ-034 SHALL cover: hppa=0xC0409 -> no arvalid, lkup_err_o=1, allow_access=0 on the cycle after acceptance.
REQ-035 SHALL cover: zeroBlkWr=1 with entry zpd_cnt=0xFF -> zpd_update=1, zpd_cnt=0xFF; with zpd_cnt=0x05 -> zpd_cnt=0x06.
REQ-036 SHALL cover: sts=00 and sts=10 -> allow_access=0, lkup_err_o=0; rresp=2'b10 -> lkup_err_o=1.
REQ-037 SHALL cover: arready delayed 4 cycles and trnsl_ready_i delayed 5 cycles -> addr and trnsl_o stable throughout, lkup_ready_o=0 throughout.
REQ-038 SHALL cover: rst_ni asserted while in DATA -> IDLE, outputs 0, lkup_ready_o=1 after reset, next lookup completes correctly.

Source files
------------

// File: rtl/hawk_att_lkup_pkg.sv
// Shared HACD types, constants and helpers used by the ATT lookup block.
package hacd_pkg;

  localparam int unsigned HACD_AXI4_ADDR_WIDTH = 40;
  localparam int unsigned HACD_AXI4_DATA_WIDTH = 512;

  localparam logic [HACD_AXI4_ADDR_WIDTH-1:0] HAWK_ATT_START = 40'h00_C000_0000;
  localparam logic [HACD_AXI4_ADDR_WIDTH-1:0] HPPA_BASE_ADDR = 40'h00_C040_0000;
  localparam int unsigned                      ATT_ENTRY_CNT  = 8;

  localparam logic [1:0] STS_INVALID = 2'b00;
  localparam logic [1:0] STS_UNCOMP  = 2'b01;
  localparam logic [1:0] STS_COMP    = 2'b10;
  localparam logic [1:0] STS_INCOMP  = 2'b11;

  // One 64-bit ATT entry; way occupies bits [ADDR_W-1:12].
  typedef struct packed {
    logic [1:0]                     sts;
    logic [13:0]                    rsvd_hi;
    logic [7:0]                     zpd_cnt;
    logic [HACD_AXI4_ADDR_WIDTH-13:0] way;
    logic [11:0]                    rsvd_lo;
  } AttEntry;

  typedef struct packed {
    logic                             lookup;
    logic                             zeroBlkWr;
    logic [HACD_AXI4_ADDR_WIDTH-13:0] hppa;
  } att_lkup_reqpkt_t;

  typedef struct packed {
    logic                            arvalid;
    logic [HACD_AXI4_ADDR_WIDTH-1:0] araddr;
    logic [7:0]                      arlen;
    logic                            rready;
  } axi_rd_reqpkt_t;

  typedef struct packed {
    logic arready;
  } axi_rd_rdypkt_t;

  typedef struct packed {
    logic                            rvalid;
    logic [HACD_AXI4_DATA_WIDTH-1:0] rdata;
    logic [1:0]                      rresp;
    logic                            rlast;
  } axi_rd_resppkt_t;

  typedef struct packed {
    logic [HACD_AXI4_ADDR_WIDTH-1:0] ppa;
    logic [1:0]                      sts;
    logic                            allow_access;
    logic                            zpd_update;
    logic [7:0]                      zpd_cnt;
  } trnsl_reqpkt_t;

  typedef enum logic [1:0] {
    ATT_IDLE,
    ATT_ADDR,
    ATT_DATA,
    ATT_RESP
  } att_lkup_state_e;

  // ATT lines are stored big-endian per 8-byte word; reverse bytes within each word.
  function automatic logic [HACD_AXI4_DATA_WIDTH-1:0] get_8byte_byteswap(
    input logic [HACD_AXI4_DATA_WIDTH-1:0] d
  );
    logic [HACD_AXI4_DATA_WIDTH-1:0] r;
    r = '0;
    for (int unsigned w = 0; w < HACD_AXI4_DATA_WIDTH / 64; w++) begin
      for (int unsigned b = 0; b < 8; b++) begin
        r[64*w + 8*b +: 8] = d[64*w + 8*(7-b) +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hawk_att_lkup_if.sv
// Bundle of the ATT lookup request, AXI read and translation-result signals.
// master: requester/environment side; slave: the lookup block side.
interface hawk_att_lkup_if;
  import hacd_pkg::*;

  att_lkup_reqpkt_t lkup_req;
  logic             lkup_ready;
  axi_rd_reqpkt_t   rd_req;
  axi_rd_rdypkt_t   rd_rdy;
  axi_rd_resppkt_t  rd_resp;
  trnsl_reqpkt_t    trnsl;
  logic             trnsl_valid;
  logic             trnsl_ready;
  logic             lkup_err;

  modport master (
    output lkup_req, rd_rdy, rd_resp, trnsl_ready,
    input  lkup_ready, rd_req, trnsl, trnsl_valid, lkup_err
  );

  modport slave (
    input  lkup_req, rd_rdy, rd_resp, trnsl_ready,
    output lkup_ready, rd_req, trnsl, trnsl_valid, lkup_err
  );
endinterface

// File: rtl/hawk_att_lkup.sv
// ATT lookup: maps a host page number to an ATT entry, fetches the 64-byte
// ATT line over AXI, and returns the translation with access/ZPD decisions.
module hawk_att_lkup
  import hacd_pkg::*;
#(
  parameter logic [HACD_AXI4_ADDR_WIDTH-1:0] ATT_BASE  = HAWK_ATT_START,
  parameter logic [HACD_AXI4_ADDR_WIDTH-1:0] HPPA_BASE = HPPA_BASE_ADDR,
  parameter int unsigned                     ENTRY_CNT = ATT_ENTRY_CNT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  att_lkup_reqpkt_t lkup_req_i,
  output logic             lkup_ready_o,
  output axi_rd_reqpkt_t   rd_req_o,
  input  axi_rd_rdypkt_t   rd_rdy_i,
  input  axi_rd_resppkt_t  rd_resp_i,
  output trnsl_reqpkt_t    trnsl_o,
  output logic             trnsl_valid_o,
  input  logic             trnsl_ready_i,
  output logic             lkup_err_o
);

  localparam int unsigned ADDR_W = HACD_AXI4_ADDR_WIDTH;
  localparam int unsigned DATA_W = HACD_AXI4_DATA_WIDTH;
  localparam int unsigned PN_W   = ADDR_W - 12;
  localparam logic [PN_W-1:0] BASE_PN = HPPA_BASE[ADDR_W-1:12];
  localparam logic [PN_W-1:0] CNT_PN  = PN_W'(ENTRY_CNT);

  att_lkup_state_e   state_q, state_d;
  logic [PN_W-1:0]   idx_d, idx_q;
  logic              oor_d, oor_q;
  logic              zblk_q;
  logic [DATA_W-1:0] line_q;
  logic [1:0]        rresp_q;
  logic              accept;
  logic              beat_last;
  logic [DATA_W-1:0] swapped;
  AttEntry           entry;
  logic              entry_unused;

  assign accept    = lkup_req_i.lookup && (state_q == ATT_IDLE);
  assign beat_last = (state_q == ATT_DATA) && rd_resp_i.rvalid && rd_resp_i.rlast;
  // A page below the base wraps to a huge index and is caught by the range check.
  assign idx_d     = lkup_req_i.hppa - BASE_PN;
  assign oor_d     = (idx_d >= CNT_PN);

  assign swapped      = get_8byte_byteswap(line_q);
  assign entry        = AttEntry'(swapped[{idx_q[2:0], 6'd0} +: 64]);
  assign entry_unused = ^{entry.rsvd_hi, entry.rsvd_lo};

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ATT_IDLE;
    else         state_q <= state_d;
  end

  // Capture request on acceptance and the final read beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= '0;
      oor_q   <= 1'b0;
      zblk_q  <= 1'b0;
      line_q  <= '0;
      rresp_q <= '0;
    end else begin
      if (accept) begin
        idx_q  <= idx_d;
        oor_q  <= oor_d;
        zblk_q <= lkup_req_i.zeroBlkWr;
      end
      if (beat_last) begin
        line_q  <= rd_resp_i.rdata;
        rresp_q <= rd_resp_i.rresp;
      end
    end
  end

  // Next state and AXI/handshake outputs.
  always_comb begin
    state_d      = state_q;
    lkup_ready_o = 1'b0;
    rd_req_o     = '0;
    unique case (state_q)
      ATT_IDLE: begin
        lkup_ready_o = 1'b1;
        if (lkup_req_i.lookup) state_d = oor_d ? ATT_RESP : ATT_ADDR;
      end
      ATT_ADDR: begin
        rd_req_o.arvalid = 1'b1;
        rd_req_o.araddr  = ATT_BASE + ADDR_W'({idx_q[PN_W-1:3], 6'd0});
        rd_req_o.arlen   = 8'd0;
        if (rd_rdy_i.arready) state_d = ATT_DATA;
      end
      ATT_DATA: begin
        rd_req_o.rready = 1'b1;
        if (beat_last) state_d = ATT_RESP;
      end
      ATT_RESP: begin
        if (trnsl_ready_i) state_d = ATT_IDLE;
      end
      default: state_d = ATT_IDLE;
    endcase
  end

  // Translation result, driven only while the response is presented.
  always_comb begin
    trnsl_o       = '0;
    trnsl_valid_o = 1'b0;
    lkup_err_o    = 1'b0;
    if (state_q == ATT_RESP) begin
      trnsl_valid_o = 1'b1;
      if (oor_q) begin
        lkup_err_o = 1'b1;
      end else begin
        lkup_err_o           = (rresp_q != 2'b00);
        trnsl_o.sts          = entry.sts;
        trnsl_o.ppa          = {entry.way, 12'h000};
        trnsl_o.allow_access = ((entry.sts == STS_UNCOMP) || (entry.sts == STS_INCOMP))
                               && (rresp_q == 2'b00);
        trnsl_o.zpd_update   = zblk_q;
        if (zblk_q) trnsl_o.zpd_cnt = (entry.zpd_cnt == 8'hFF) ? 8'hFF : entry.zpd_cnt + 8'd1;
        else        trnsl_o.zpd_cnt = entry.zpd_cnt;
      end
    end
  end

endmodule

// File: tb/tb_hawk_att_lkup.sv
// Randomized self-checking bench for hawk_att_lkup with a behavioural ATT model.
module tb_hawk_att_lkup;
  import hacd_pkg::*;

  localparam logic [39:0] T_ATT_BASE  = 40'h00_C000_0000;
  localparam logic [39:0] T_HPPA_BASE = 40'h00_C040_0000;
  localparam logic [27:0] BASE_PN     = 28'hC0400;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hawk_att_lkup_if bus();

  hawk_att_lkup #(
    .ATT_BASE (T_ATT_BASE),
    .HPPA_BASE(T_HPPA_BASE),
    .ENTRY_CNT(8)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .lkup_req_i   (bus.lkup_req),
    .lkup_ready_o (bus.lkup_ready),
    .rd_req_o     (bus.rd_req),
    .rd_rdy_i     (bus.rd_rdy),
    .rd_resp_i    (bus.rd_resp),
    .trnsl_o      (bus.trnsl),
    .trnsl_valid_o(bus.trnsl_valid),
    .trnsl_ready_i(bus.trnsl_ready),
    .lkup_err_o   (bus.lkup_err)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc;

  logic [63:0] ent [8];

  logic        exp_err, exp_allow, exp_zu;
  logic [1:0]  exp_sts;
  logic [39:0] exp_ppa;
  logic [7:0]  exp_zc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_ent(input int unsigned i, input logic [1:0] sts,
                         input logic [7:0] zpd, input logic [27:0] way);
    ent[i] = {sts, 14'($urandom), zpd, way, 12'($urandom)};
  endtask

  // Memory image: entry i occupies bytes 8i..8i+7, most significant byte first.
  function automatic logic [511:0] build_line();
    logic [511:0] l;
    logic [63:0]  e;
    for (int i = 0; i < 8; i++) begin
      e = ent[i];
      for (int m = 0; m < 8; m++) l[8*(8*i+m) +: 8] = e[8*(7-m) +: 8];
    end
    return l;
  endfunction

  task automatic check_resp(input string tag);
    chk({tag, "_valid"}, 64'(bus.trnsl_valid), 64'(1'b1));
    chk({tag, "_err"},   64'(bus.lkup_err), 64'(exp_err));
    chk({tag, "_sts"},   64'(bus.trnsl.sts), 64'(exp_sts));
    chk({tag, "_ppa"},   64'(bus.trnsl.ppa), 64'(exp_ppa));
    chk({tag, "_allow"}, 64'(bus.trnsl.allow_access), 64'(exp_allow));
    chk({tag, "_zu"},    64'(bus.trnsl.zpd_update), 64'(exp_zu));
    chk({tag, "_zc"},    64'(bus.trnsl.zpd_cnt), 64'(exp_zc));
  endtask

  task automatic run_lookup(input logic [27:0] hppa, input logic zblk,
                            input int unsigned ar_dly, input int unsigned rd_dly,
                            input logic [1:0] rresp, input bit junk, input bit chk_lat);
    logic [27:0]  d;
    logic [63:0]  e;
    logic [39:0]  exp_addr;
    logic         oor;
    int unsigned  zc, n;
    d   = hppa - BASE_PN;
    oor = (d >= 28'd8);
    exp_addr = T_ATT_BASE + 40'((d / 8) * 64);
    if (oor) begin
      exp_err = 1'b1; exp_sts = 2'b00; exp_ppa = '0; exp_allow = 1'b0; exp_zu = 1'b0; exp_zc = '0;
    end else begin
      e         = ent[d];
      exp_sts   = e[63:62];
      exp_ppa   = {e[39:12], 12'h000};
      exp_err   = (rresp != 2'b00);
      exp_allow = (exp_sts == 2'b01 || exp_sts == 2'b11) && (rresp == 2'b00);
      exp_zu    = zblk;
      zc        = int'(e[47:40]);
      if (zblk) zc = (zc + 1 > 255) ? 255 : zc + 1;
      exp_zc    = 8'(zc);
    end

    chk("ready_idle", 64'(bus.lkup_ready), 64'(1'b1));
    bus.lkup_req.lookup    = 1'b1;
    bus.lkup_req.hppa      = hppa;
    bus.lkup_req.zeroBlkWr = zblk;
    cyc = 0;
    step();
    bus.lkup_req.lookup = 1'b0;

    if (oor) begin
      chk("oor_no_ar", 64'(bus.rd_req.arvalid), 64'(1'b0));
    end else begin
      n = 0;
      while (!bus.rd_req.arvalid && n < 8) begin step(); n++; end
      chk("arvalid", 64'(bus.rd_req.arvalid), 64'(1'b1));
      if (chk_lat) chk("ar_lat", 64'(cyc), 64'(1));
      chk("araddr", 64'(bus.rd_req.araddr), 64'(exp_addr));
      chk("arlen", 64'(bus.rd_req.arlen), 64'(0));
      repeat (ar_dly) begin
        chk("busy_ar", 64'(bus.lkup_ready), 64'(1'b0));
        step();
        chk("araddr_hold", 64'(bus.rd_req.araddr), 64'(exp_addr));
        chk("arvalid_hold", 64'(bus.rd_req.arvalid), 64'(1'b1));
        chk("arlen_hold", 64'(bus.rd_req.arlen), 64'(0));
      end
      bus.rd_rdy.arready = 1'b1;
      step();
      bus.rd_rdy.arready = 1'b0;
      chk("rready", 64'(bus.rd_req.rready), 64'(1'b1));
      chk("ar_drop", 64'(bus.rd_req.arvalid), 64'(1'b0));
      if (junk) begin
        bus.rd_resp.rvalid = 1'b1;
        bus.rd_resp.rlast  = 1'b0;
        bus.rd_resp.rdata  = {16{$urandom}};
        bus.rd_resp.rresp  = 2'($urandom);
        step();
        chk("junk_ignored", 64'(bus.trnsl_valid), 64'(1'b0));
        chk("rready_hold", 64'(bus.rd_req.rready), 64'(1'b1));
      end
      bus.rd_resp.rvalid = 1'b1;
      bus.rd_resp.rlast  = 1'b1;
      bus.rd_resp.rdata  = build_line();
      bus.rd_resp.rresp  = rresp;
      step();
      bus.rd_resp.rvalid = 1'b0;
      bus.rd_resp.rlast  = 1'b0;
    end

    n = 0;
    while (!bus.trnsl_valid && n < 8) begin step(); n++; end
    if (chk_lat) chk("latency", 64'(cyc), oor ? 64'(1) : 64'(3));
    check_resp("resp");
    repeat (rd_dly) begin
      chk("busy_resp", 64'(bus.lkup_ready), 64'(1'b0));
      step();
      check_resp("resp_hold");
    end
    bus.trnsl_ready = 1'b1;
    step();
    bus.trnsl_ready = 1'b0;
    chk("valid_drop", 64'(bus.trnsl_valid), 64'(1'b0));
    chk("ready_back", 64'(bus.lkup_ready), 64'(1'b1));
  endtask

  initial begin
    logic [1:0]  rr;
    logic [27:0] hp;
    bus.lkup_req    = '0;
    bus.rd_rdy      = '0;
    bus.rd_resp     = '0;
    bus.trnsl_ready = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) ent[i] = {$urandom, $urandom};

    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(bus.lkup_ready), 64'(1'b1));
    chk("rst_rdreq", 64'(bus.rd_req), 64'(0));
    chk("rst_valid", 64'(bus.trnsl_valid), 64'(1'b0));
    chk("rst_err", 64'(bus.lkup_err), 64'(1'b0));
    chk("rst_trnsl", 64'(bus.trnsl), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Slot 3 maps to ppa 0x12345000, uncompressed.
    set_ent(3, 2'b01, 8'h10, 28'h0012345);
    run_lookup(28'hC0403, 1'b0, 0, 0, 2'b00, 1'b0, 1'b1);
    // Out of range.
    run_lookup(28'hC0409, 1'b0, 0, 0, 2'b00, 1'b0, 1'b1);
    run_lookup(28'hC03FF, 1'b1, 0, 0, 2'b00, 1'b0, 1'b1);
    // ZPD counter update and saturation.
    set_ent(5, 2'b11, 8'hFF, 28'h0ABCDE);
    run_lookup(28'hC0405, 1'b1, 0, 0, 2'b00, 1'b0, 1'b1);
    set_ent(6, 2'b01, 8'h05, 28'h0000777);
    run_lookup(28'hC0406, 1'b1, 0, 0, 2'b00, 1'b0, 1'b1);
    // Status decode and error response.
    set_ent(0, 2'b00, 8'h01, 28'h0001111);
    run_lookup(28'hC0400, 1'b0, 0, 0, 2'b00, 1'b0, 1'b1);
    set_ent(7, 2'b10, 8'h02, 28'h0002222);
    run_lookup(28'hC0407, 1'b0, 0, 0, 2'b00, 1'b0, 1'b1);
    set_ent(1, 2'b01, 8'h03, 28'h0003333);
    run_lookup(28'hC0401, 1'b0, 0, 0, 2'b10, 1'b0, 1'b1);
    // Back-pressure on both handshakes, plus a non-last beat.
    set_ent(2, 2'b11, 8'h44, 28'h0FEDCBA);
    run_lookup(28'hC0402, 1'b0, 4, 5, 2'b00, 1'b1, 1'b0);

    // Reset while waiting for read data.
    bus.lkup_req.lookup = 1'b1;
    bus.lkup_req.hppa   = 28'hC0404;
    @(negedge clk);
    bus.lkup_req.lookup = 1'b0;
    bus.rd_rdy.arready  = 1'b1;
    @(negedge clk);
    bus.rd_rdy.arready  = 1'b0;
    chk("pre_rst_rready", 64'(bus.rd_req.rready), 64'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(bus.lkup_ready), 64'(1'b1));
    chk("mid_rst_rdreq", 64'(bus.rd_req), 64'(0));
    chk("mid_rst_valid", 64'(bus.trnsl_valid), 64'(1'b0));
    chk("mid_rst_err", 64'(bus.lkup_err), 64'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 64'(bus.lkup_ready), 64'(1'b1));
    chk("post_rst_valid", 64'(bus.trnsl_valid), 64'(1'b0));
    set_ent(4, 2'b01, 8'h09, 28'h0055555);
    run_lookup(28'hC0404, 1'b1, 0, 0, 2'b00, 1'b0, 1'b1);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 8; i++) ent[i] = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ent[$urandom_range(0, 7)][47:40] = 8'hFF;
      hp = ($urandom_range(0, 9) == 0) ? 28'hC03FF : BASE_PN + 28'($urandom_range(0, 10));
      rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_lookup(hp, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 rr, 1'($urandom), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
